// File: rtl/uart_rx_framer.sv
// UART 8N1 receive framer: synchronises rxd, samples each bit at mid-period, emits good bytes or framing errors.
// Optional build macro UART_RX_MAJORITY_EN selects a 2-of-3 majority vote for every bit decision.
module uart_rx_framer #(
  parameter int unsigned CLK_PER_HALF_BIT = 520
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       ferr,
  output logic       busy
);

  localparam int unsigned H  = CLK_PER_HALF_BIT;
  localparam int unsigned CW = $clog2(2 * H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            sync1;
  logic            rxs;
  logic            samp_c;
  logic            half_done_c;
  logic            full_done_c;

  // Two-flop synchroniser, idle-high reset value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic hist1;
  logic hist2;

  // History of the two cycles preceding the decision cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist1 <= 1'b1;
      hist2 <= 1'b1;
    end else begin
      hist1 <= rxs;
      hist2 <= hist1;
    end
  end

  assign samp_c = (rxs & hist1) | (rxs & hist2) | (hist1 & hist2);
`else
  assign samp_c = rxs;
`endif

  assign half_done_c = (cnt == CW'(H - 1));
  assign full_done_c = (cnt == CW'(2 * H - 1));

  // Frame FSM with registered outputs; cnt restarts on each state entry and bit decision.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      ferr     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      ferr     <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (half_done_c) begin
            cnt <= '0;
            if (samp_c) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (full_done_c) begin
            cnt     <= '0;
            shreg   <= {samp_c, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (full_done_c) begin
            cnt <= '0;
            if (samp_c) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= S_IDLE;
              busy     <= 1'b0;
            end else begin
              ferr  <= 1'b1;
              state <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_BREAK: begin
          // Held-low line: wait for the line to go idle before hunting a new start bit.
          cnt <= '0;
          if (rxs) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer at H=4: per-cycle schedule model plus literal pins on latency and byte order.
module tb_uart_rx_framer;

  localparam int H = 4;
  localparam int N = 4096;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GLITCH_BYTE = 8'h01;
`else
  localparam logic [7:0] GLITCH_BYTE = 8'h00;
`endif

  logic       clk;
  logic       rstn;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ferr;
  logic       busy;

  uart_rx_framer #(.CLK_PER_HALF_BIT(H)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .ferr     (ferr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle behaviour, filled ahead of time by the stimulus.
  bit         ev_valid [N];
  bit         ev_ferr  [N];
  bit         exp_busy [N];
  bit         in_rst   [N];
  logic [7:0] ev_byte  [N];

  int         checks = 0;
  int         errors = 0;
  bit         done = 0;
  int         e55 = 0;
  int         nferr = 0;
  int         pulse_cyc [$];
  logic [7:0] pulse_dat [$];
  logic [7:0] model_data = 8'h00;

  task automatic mark_busy(input int from, input int to);
    for (int i = from; i <= to; i++) if (i >= 0 && i < N) exp_busy[i] = 1'b1;
  endtask

  task automatic drive(input logic v, input int n);
    rxd = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame; stop=0 holds the line low for hold extra cycles after the stop cell.
  task automatic send_frame(input logic [7:0] d, input logic [7:0] exp_d, input bit stop,
                            input int glitch_bit, input int hold, output int c);
    c = cyc;
    if (stop) begin
      ev_valid[c + 19*H + 3] = 1'b1;
      ev_byte[c + 19*H + 3]  = exp_d;
      mark_busy(c + 3, c + 19*H + 2);
    end else begin
      ev_ferr[c + 19*H + 3] = 1'b1;
      mark_busy(c + 3, c + 20*H + hold + 2);
    end
    drive(1'b0, 2*H);
    for (int k = 0; k < 8; k++) begin
      if (k == glitch_bit) begin
        drive(d[k], H);
        drive(1'b0, 1);
        drive(d[k], H - 1);
      end else begin
        drive(d[k], 2*H);
      end
    end
    drive(stop, 2*H);
    if (!stop) drive(1'b0, hold);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Single compare process: per-cycle checks, then literal pins and summary.
  always @(negedge clk) begin
    if (cyc > 0 && cyc < N) begin
      logic ev, ef, eb;
      if (in_rst[cyc]) begin
        model_data = 8'h00;
        ev = 1'b0; ef = 1'b0; eb = 1'b0;
      end else begin
        if (ev_valid[cyc]) model_data = ev_byte[cyc];
        ev = ev_valid[cyc]; ef = ev_ferr[cyc]; eb = exp_busy[cyc];
      end
      chk("rx_valid", 32'(rx_valid), 32'(ev));
      chk("ferr", 32'(ferr), 32'(ef));
      chk("busy", 32'(busy), 32'(eb));
      chk("rx_data", 32'(rx_data), 32'(model_data));
      if (rx_valid === 1'b1) begin
        pulse_cyc.push_back(cyc);
        pulse_dat.push_back(rx_data);
      end
      if (ferr === 1'b1) nferr++;
    end
    if (done) begin
      logic [7:0] seq [9];
      seq = '{8'h55, 8'hA3, 8'h3C, 8'h3C, 8'h00, 8'hFF, 8'h81, 8'h12, GLITCH_BYTE};
      chk("pulse_count", 32'(pulse_cyc.size()), 32'd9);
      for (int i = 0; i < 9; i++)
        if (i < pulse_dat.size()) chk("byte_order", 32'(pulse_dat[i]), 32'(seq[i]));
      if (pulse_cyc.size() >= 7) begin
        chk("latency_79", 32'(pulse_cyc[0] - e55), 32'd79);
        chk("b2b_gap_1", 32'(pulse_cyc[5] - pulse_cyc[4]), 32'd80);
        chk("b2b_gap_2", 32'(pulse_cyc[6] - pulse_cyc[5]), 32'd80);
      end
      chk("ferr_count", 32'(nferr), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    int c;
    int r;
    rstn = 1'b0;
    rxd  = 1'b1;
    for (int i = 1; i <= 5; i++) in_rst[i] = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b1;
    drive(1'b1, 2*H);

    // Two frames, one idle bit after each.
    send_frame(8'h55, 8'h55, 1'b1, -1, 0, c);
    e55 = c;
    drive(1'b1, 2*H);
    send_frame(8'hA3, 8'hA3, 1'b1, -1, 0, c);
    drive(1'b1, 2*H);

    // Two-cycle start glitch is rejected at the start decision.
    c = cyc;
    mark_busy(c + 3, c + H + 2);
    drive(1'b0, 2);
    drive(1'b1, 4*H);
    send_frame(8'h3C, 8'h3C, 1'b1, -1, 0, c);
    drive(1'b1, 2*H);

    // Framing error, line held low, then recovery.
    send_frame(8'hA5, 8'h00, 1'b0, -1, 30, c);
    drive(1'b1, 4*H);
    send_frame(8'h3C, 8'h3C, 1'b1, -1, 0, c);
    drive(1'b1, 2*H);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 8'h00, 1'b1, -1, 0, c);
    send_frame(8'hFF, 8'hFF, 1'b1, -1, 0, c);
    send_frame(8'h81, 8'h81, 1'b1, -1, 0, c);
    drive(1'b1, 2*H);

    // Reset during bit 3 of 0x7E aborts the frame silently.
    c = cyc;
    mark_busy(c + 3, c + 2 + H + 2*3*H + 2*H);
    drive(1'b0, 2*H);
    drive(1'b0, 2*H);
    drive(1'b1, 2*H);
    drive(1'b1, 2*H);
    drive(1'b1, H);
    r = cyc;
    for (int i = r + 1; i < N; i++) begin
      ev_valid[i] = 1'b0;
      ev_ferr[i]  = 1'b0;
      exp_busy[i] = 1'b0;
    end
    for (int i = r + 1; i <= r + 6; i++) in_rst[i] = 1'b1;
    rstn = 1'b0;
    drive(1'b1, 6);
    rstn = 1'b1;
    drive(1'b1, 4*H);
    send_frame(8'h12, 8'h12, 1'b1, -1, 0, c);
    drive(1'b1, 2*H);

    // One-cycle low glitch on bit 0 at its decision cycle.
    send_frame(8'h01, GLITCH_BYTE, 1'b1, 0, 0, c);
    drive(1'b1, 8*H);
    done = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL summary_not_reached cycle %0d", cyc);
    $fatal(1);
  end

endmodule
